csi_tx_ppi_gen: RTL and testbench

CSI-2 transmit-side packet generator that drives 4-lane byte-level HS PPI streams (`tx_valid_hsN` / `tx_data_hsN`) in the format consumed by the CSI-2 receiver's `rx_valid_hsN` / `rx_data_hsN` inputs. Per frame it emits:
- Frame Start short packet;
- `line_count` long packets carrying a deterministic pixel pattern with ECC-protected headers and CRC-16 footers;
- Frame End short packet.

It sits in the FPGA test harness in front of the receiver, in the byte clock domain. It replaces the D-PHY for loopback and regression.

---
 rtl/csi_tx_ppi_gen.sv | 221 ++++++++++++++++++++++
 tb/tb_csi_tx_ppi_gen.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csi_tx_ppi_gen.sv
// CSI-2 transmit packet generator for 4-lane byte-level HS PPI: per frame emits
// FS, line_count long packets (ECC header, pattern payload, CRC-16) and FE.
module csi_tx_ppi_gen #(
   parameter int GAP_CYCLES = 4
) (
   input  logic        byte_clk_i,
   input  logic        reset_n_i,
   input  logic        start_i,
   input  logic [1:0]  vc_i,
   input  logic [5:0]  dt_i,
   input  logic [15:0] wc_i,
   input  logic [15:0] line_count_i,
   output logic        busy_o,
   output logic        frame_done_o,
   output logic        tx_valid_hs0_o,
   output logic        tx_valid_hs1_o,
   output logic        tx_valid_hs2_o,
   output logic        tx_valid_hs3_o,
   output logic [7:0]  tx_data_hs0_o,
   output logic [7:0]  tx_data_hs1_o,
   output logic [7:0]  tx_data_hs2_o,
   output logic [7:0]  tx_data_hs3_o
);

   typedef enum logic [2:0] {IDLE, FS, GAP, LHDR, LDATA, FE} state_t;

   localparam logic [7:0] GAP_LOAD = 8'(GAP_CYCLES - 1);

   state_t      state;
   state_t      after_gap;
   logic [7:0]  gap_cnt;
   logic [15:0] line_idx;
   logic [15:0] frame_num;
   logic        busy;
   logic        done;
   logic [3:0]  lane_vld;
   logic [31:0] lane_data;

   logic [1:0]  vc;
   logic [5:0]  dt;
   logic [15:0] wc;
   logic [15:0] lines;
   logic [17:0] pos;
   logic [15:0] crc;

   logic [15:0] frame_next;
   logic [31:0] fs_hdr;
   logic [31:0] line_hdr;
   logic [31:0] fe_hdr;
   logic [17:0] data_len;
   logic        more_lines;
   logic        accept;
   logic [3:0]  chunk_vld;
   logic [31:0] chunk_data;
   logic [15:0] crc_fin;
   logic [17:0] chunk_pos;

   // CSI-2 v1.x Hamming parity; each mask selects the header bits feeding one parity bit.
   function automatic logic [5:0] hdr_ecc(input logic [23:0] d);
      logic [5:0] e;
      e[0] = ^(d & 24'hF12CB7);
      e[1] = ^(d & 24'hF2555B);
      e[2] = ^(d & 24'h749A6D);
      e[3] = ^(d & 24'hB8E38E);
      e[4] = ^(d & 24'hDF03F0);
      e[5] = ^(d & 24'hEFFC00);
      return e;
   endfunction

   function automatic logic [31:0] pkt_header(input logic [1:0] v, input logic [5:0] t,
                                               input logic [15:0] w);
      logic [23:0] d;
      d = {w, v, t};
      return {2'b00, hdr_ecc(d), d};
   endfunction

   function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [7:0] b);
      logic [15:0] r;
      r = c ^ {8'h00, b};
      for (int i = 0; i < 8; i++) begin
         r = r[0] ? ((r >> 1) ^ 16'h8408) : (r >> 1);
      end
      return r;
   endfunction

   assign accept     = (state == IDLE) && start_i;
   assign frame_next = (frame_num == 16'hFFFF) ? 16'h0001 : frame_num + 16'h0001;
   assign fs_hdr     = pkt_header(vc_i, 6'h00, frame_next);
   assign line_hdr   = pkt_header(vc, dt, wc);
   assign fe_hdr     = pkt_header(vc, 6'h01, frame_num);
   assign data_len   = {2'b00, wc} + 18'd2;
   assign more_lines = ({1'b0, line_idx} + 17'd1) < {1'b0, lines};

   // One data cycle: payload lanes first (folded into the CRC), then the CRC bytes,
   // which may share the cycle with the final payload bytes.
   always_comb begin
      crc_fin    = crc;
      chunk_vld  = '0;
      chunk_data = '0;
      chunk_pos  = '0;
      for (int i = 0; i < 4; i++) begin
         chunk_pos = pos + 18'(i);
         if (chunk_pos < {2'b00, wc}) begin
            chunk_vld[i]         = 1'b1;
            chunk_data[8*i +: 8] = line_idx[7:0] + chunk_pos[7:0];
            crc_fin              = crc_step(crc_fin, line_idx[7:0] + chunk_pos[7:0]);
         end
      end
      for (int i = 0; i < 4; i++) begin
         chunk_pos = pos + 18'(i);
         if (chunk_pos == {2'b00, wc}) begin
            chunk_vld[i]         = 1'b1;
            chunk_data[8*i +: 8] = crc_fin[7:0];
         end else if (chunk_pos == data_len - 18'd1) begin
            chunk_vld[i]         = 1'b1;
            chunk_data[8*i +: 8] = crc_fin[15:8];
         end
      end
   end

   always_ff @(posedge byte_clk_i) begin
      if (accept) begin
         vc    <= vc_i;
         dt    <= dt_i;
         wc    <= wc_i;
         lines <= line_count_i;
      end
   end

   always_ff @(posedge byte_clk_i) begin
      if (!reset_n_i) begin
         state     <= IDLE;
         after_gap <= IDLE;
         gap_cnt   <= '0;
         line_idx  <= '0;
         frame_num <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         lane_vld  <= '0;
         lane_data <= '0;
      end else begin
         done      <= 1'b0;
         lane_vld  <= '0;
         lane_data <= '0;
         case (state)
            IDLE: begin
               if (start_i) begin
                  state     <= FS;
                  busy      <= 1'b1;
                  frame_num <= frame_next;
                  line_idx  <= '0;
                  lane_vld  <= 4'hF;
                  lane_data <= fs_hdr;
               end
            end
            FS: begin
               state     <= GAP;
               gap_cnt   <= GAP_LOAD;
               after_gap <= (lines != 16'd0) ? LHDR : FE;
            end
            GAP: begin
               if (gap_cnt == 8'd0) begin
                  case (after_gap)
                     LHDR: begin
                        state     <= LHDR;
                        lane_vld  <= 4'hF;
                        lane_data <= line_hdr;
                        pos       <= '0;
                        crc       <= 16'hFFFF;
                     end
                     FE: begin
                        state     <= FE;
                        lane_vld  <= 4'hF;
                        lane_data <= fe_hdr;
                     end
                     default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                     end
                  endcase
               end else begin
                  gap_cnt <= gap_cnt - 8'd1;
               end
            end
            LHDR, LDATA: begin
               if (pos < data_len) begin
                  state     <= LDATA;
                  lane_vld  <= chunk_vld;
                  lane_data <= chunk_data;
                  pos       <= pos + 18'd4;
                  crc       <= crc_fin;
               end else begin
                  state     <= GAP;
                  gap_cnt   <= GAP_LOAD;
                  line_idx  <= line_idx + 16'd1;
                  after_gap <= more_lines ? LHDR : FE;
               end
            end
            FE: begin
               state     <= GAP;
               gap_cnt   <= GAP_LOAD;
               after_gap <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign busy_o         = busy;
   assign frame_done_o   = done;
   assign tx_valid_hs0_o = lane_vld[0];
   assign tx_valid_hs1_o = lane_vld[1];
   assign tx_valid_hs2_o = lane_vld[2];
   assign tx_valid_hs3_o = lane_vld[3];
   assign tx_data_hs0_o  = lane_data[7:0];
   assign tx_data_hs1_o  = lane_data[15:8];
   assign tx_data_hs2_o  = lane_data[23:16];
   assign tx_data_hs3_o  = lane_data[31:24];

endmodule

// File: tb/tb_csi_tx_ppi_gen.sv
// Bench for csi_tx_ppi_gen: frame-level reference model built from byte lists,
// a table of frame shapes, and hand sequences for reset, wrap and start corners.
module tb_csi_tx_ppi_gen;
   localparam int G = 4;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic [1:0]  vc = '0;
   logic [5:0]  dt = '0;
   logic [15:0] wc = '0;
   logic [15:0] line_count = '0;
   logic        busy;
   logic        frame_done;
   logic        v0, v1, v2, v3;
   logic [7:0]  d0, d1, d2, d3;

   csi_tx_ppi_gen #(.GAP_CYCLES(G)) dut (
      .byte_clk_i    (clk),
      .reset_n_i     (reset_n),
      .start_i       (start),
      .vc_i          (vc),
      .dt_i          (dt),
      .wc_i          (wc),
      .line_count_i  (line_count),
      .busy_o        (busy),
      .frame_done_o  (frame_done),
      .tx_valid_hs0_o(v0),
      .tx_valid_hs1_o(v1),
      .tx_valid_hs2_o(v2),
      .tx_valid_hs3_o(v3),
      .tx_data_hs0_o (d0),
      .tx_data_hs1_o (d1),
      .tx_data_hs2_o (d2),
      .tx_data_hs3_o (d3)
   );

   always #5 clk = ~clk;

   typedef struct { logic [3:0] vld; logic [31:0] data; logic busy; logic done; } cyc_t;
   typedef struct { logic [1:0] vc; logic [5:0] dt; logic [15:0] wc; logic [15:0] lines; } cfg_t;
   typedef struct { cfg_t cfg; bit noise; int exp_len; int exp_last; } vec_t;

   // Syndrome column of each header data bit D0..D23.
   localparam logic [5:0] ECC_COL [24] = '{
      6'h07, 6'h0B, 6'h0D, 6'h0E, 6'h13, 6'h15, 6'h16, 6'h19,
      6'h1A, 6'h1C, 6'h23, 6'h25, 6'h26, 6'h29, 6'h2A, 6'h2C,
      6'h31, 6'h32, 6'h34, 6'h38, 6'h1F, 6'h2F, 6'h37, 6'h3B};

   cyc_t        exp_q[$];
   cyc_t        obs_q[$];
   logic [7:0]  pkt[$];
   logic [15:0] mdl_fn = 16'h0000;
   int          n_checks = 0;
   int          n_err = 0;
   int          frame_no = 0;
   vec_t        vecs[9];

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
      n_checks++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
      end
   endtask

   function automatic logic [5:0] m_ecc(input logic [23:0] d);
      logic [5:0] e;
      e = '0;
      for (int i = 0; i < 24; i++) if (d[i]) e ^= ECC_COL[i];
      return e;
   endfunction

   function automatic logic [15:0] m_crc_byte(input logic [15:0] c, input logic [7:0] b);
      logic fb;
      for (int i = 0; i < 8; i++) begin
         fb = c[0] ^ b[i];
         c  = c >> 1;
         if (fb) c ^= 16'h8408;
      end
      return c;
   endfunction

   function automatic void push_header(input logic [1:0] v, input logic [5:0] t, input logic [15:0] w);
      logic [23:0] d;
      d = {w[15:8], w[7:0], v, t};
      pkt.push_back(d[7:0]);
      pkt.push_back(d[15:8]);
      pkt.push_back(d[23:16]);
      pkt.push_back({2'b00, m_ecc(d)});
   endfunction

   function automatic void emit_packet();
      int   ncyc;
      cyc_t e;
      ncyc = (pkt.size() + 3) / 4;
      for (int c = 0; c < ncyc; c++) begin
         e.vld = '0; e.data = '0; e.busy = 1'b1; e.done = 1'b0;
         for (int l = 0; l < 4; l++) begin
            if (c * 4 + l < pkt.size()) begin
               e.vld[l]         = 1'b1;
               e.data[8*l +: 8] = pkt[c * 4 + l];
            end
         end
         exp_q.push_back(e);
      end
      e.vld = '0; e.data = '0; e.busy = 1'b1; e.done = 1'b0;
      for (int g = 0; g < G; g++) exp_q.push_back(e);
      pkt.delete();
   endfunction

   function automatic void build_frame(input cfg_t c, input logic [15:0] fn);
      logic [15:0] crc;
      logic [7:0]  b;
      cyc_t        e;
      exp_q.delete();
      push_header(c.vc, 6'h00, fn);
      emit_packet();
      for (int l = 0; l < int'(c.lines); l++) begin
         push_header(c.vc, c.dt, c.wc);
         crc = 16'hFFFF;
         for (int j = 0; j < int'(c.wc); j++) begin
            b   = 8'((l + j) % 256);
            crc = m_crc_byte(crc, b);
            pkt.push_back(b);
         end
         pkt.push_back(crc[7:0]);
         pkt.push_back(crc[15:8]);
         emit_packet();
      end
      push_header(c.vc, 6'h01, fn);
      emit_packet();
      e.vld = '0; e.data = '0; e.busy = 1'b0; e.done = 1'b1;
      exp_q.push_back(e);
   endfunction

   function automatic cyc_t sample();
      cyc_t s;
      s.vld = {v3, v2, v1, v0}; s.data = {d3, d2, d1, d0};
      s.busy = busy; s.done = frame_done;
      return s;
   endfunction

   task automatic launch(input cfg_t c);
      start = 1'b1; vc = c.vc; dt = c.dt; wc = c.wc; line_count = c.lines;
   endtask

   // Called at the negedge where launch() has just driven the accepted start.
   task automatic run_frame(input cfg_t c, input bit noise, input bit chain, input cfg_t nc,
                            output int done_idx);
      cyc_t s;
      cyc_t x;
      mdl_fn = (mdl_fn == 16'hFFFF) ? 16'h0001 : mdl_fn + 16'h0001;
      build_frame(c, mdl_fn);
      obs_q.delete();
      done_idx = -1;
      frame_no++;
      for (int i = 0; i < exp_q.size(); i++) begin
         @(negedge clk);
         s = sample();
         x = exp_q[i];
         obs_q.push_back(s);
         check($sformatf("frame%0d cycle%0d {vld,data,busy,done}", frame_no, i),
               64'({s.vld, s.data, s.busy, s.done}), 64'({x.vld, x.data, x.busy, x.done}));
         if (s.done && done_idx < 0) done_idx = i;
         if (i < exp_q.size() - 1) begin
            if (noise) begin
               start = 1'($urandom_range(0, 1));
               vc = 2'($urandom); dt = 6'($urandom);
               wc = 16'($urandom); line_count = 16'($urandom);
            end else begin
               start = 1'b0;
            end
         end else if (chain) begin
            launch(nc);
         end else begin
            start = 1'b0;
         end
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      cfg_t        c;
      cfg_t        nz;
      int          di;
      int          n;
      logic [15:0] crc;
      cyc_t        s;

      nz = '{2'd0, 6'h00, 16'd0, 16'd0};
      vecs[0] = '{'{2'd0, 6'h2A, 16'd8,   16'd2}, 1'b0, 26,  2};
      vecs[1] = '{'{2'd0, 6'h2A, 16'd0,   16'd1}, 1'b1, 16,  2};
      vecs[2] = '{'{2'd1, 6'h2A, 16'd1,   16'd1}, 1'b0, 16,  3};
      vecs[3] = '{'{2'd2, 6'h2B, 16'd2,   16'd1}, 1'b1, 16,  4};
      vecs[4] = '{'{2'd3, 6'h2C, 16'd3,   16'd1}, 1'b0, 17,  1};
      vecs[5] = '{'{2'd0, 6'h2A, 16'd5,   16'd1}, 1'b1, 17,  3};
      vecs[6] = '{'{2'd1, 6'h12, 16'd100, 16'd0}, 1'b1, 10,  0};
      vecs[7] = '{'{2'd3, 6'h24, 16'd37,  16'd3}, 1'b0, 55,  3};
      vecs[8] = '{'{2'd1, 6'h2B, 16'd300, 16'd2}, 1'b1, 172, 2};

      repeat (3) @(negedge clk);
      s = sample();
      check("reset outputs", 64'({s.vld, s.data, s.busy, s.done}), 64'h0);
      reset_n = 1'b1;
      @(negedge clk);
      s = sample();
      check("idle outputs", 64'({s.vld, s.data, s.busy, s.done}), 64'h0);

      // Minimal frame: no lines.
      c = '{2'd0, 6'h2A, 16'd0, 16'd0};
      launch(c);
      run_frame(c, 1'b0, 1'b0, nz, di);
      check("minimal done cycle", 64'(di), 64'd10);
      check("minimal FS bytes0..2", 64'(obs_q[0].data[23:0]), 64'h000100);
      check("minimal FS ecc", 64'(obs_q[0].data[31:24]), 64'({2'b00, m_ecc(24'h000100)}));
      check("minimal FE bytes0..2", 64'(obs_q[5].data[23:0]), 64'h000101);
      @(negedge clk);

      // Small frame: two 8-byte lines.
      c = '{2'd0, 6'h2A, 16'd8, 16'd2};
      launch(c);
      run_frame(c, 1'b0, 1'b0, nz, di);
      check("small done cycle", 64'(di), 64'd26);
      check("small line1 payload a", 64'(obs_q[14].data), 64'h04030201);
      check("small line1 payload b", 64'(obs_q[15].data), 64'h08070605);
      crc = 16'hFFFF;
      for (int j = 1; j <= 8; j++) crc = m_crc_byte(crc, 8'(j));
      check("small line1 crc lanes", 64'(obs_q[16].vld), 64'h3);
      check("small line1 crc value", 64'(obs_q[16].data[15:0]), 64'({crc[15:8], crc[7:0]}));

      // Zero-length line.
      c = '{2'd0, 6'h2A, 16'd0, 16'd1};
      launch(c);
      run_frame(c, 1'b0, 1'b0, nz, di);
      check("wc0 header bytes0..2", 64'(obs_q[5].data[23:0]), 64'h00002A);
      check("wc0 crc valids", 64'(obs_q[6].vld), 64'h3);
      check("wc0 crc data", 64'(obs_q[6].data), 64'h0000FFFF);

      for (int k = 0; k < 9; k++) begin
         launch(vecs[k].cfg);
         run_frame(vecs[k].cfg, vecs[k].noise, 1'b0, nz, di);
         check($sformatf("vec%0d done cycle", k), 64'(di), 64'(vecs[k].exp_len));
         if (vecs[k].cfg.lines != 16'd0) begin
            n = (int'(vecs[k].cfg.wc) + 5) / 4;
            check($sformatf("vec%0d last-cycle lanes", k),
                  64'($countones(obs_q[5 + n].vld)), 64'(vecs[k].exp_last));
         end
      end

      // Reset in the middle of the first line's data.
      c = '{2'd2, 6'h2A, 16'd40, 16'd2};
      launch(c);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         start = 1'b0;
      end
      reset_n = 1'b0;
      @(negedge clk);
      s = sample();
      check("mid-frame reset outputs", 64'({s.vld, s.data, s.busy, s.done}), 64'h0);
      reset_n = 1'b1;
      mdl_fn = 16'h0000;
      @(negedge clk);
      s = sample();
      check("post-reset idle outputs", 64'({s.vld, s.data, s.busy, s.done}), 64'h0);
      c = '{2'd1, 6'h2A, 16'd6, 16'd1};
      launch(c);
      run_frame(c, 1'b1, 1'b0, nz, di);
      check("post-reset frame number", 64'(obs_q[0].data[23:8]), 64'h0001);
      @(negedge clk);

      // Frame-number wrap with back-to-back frames.
      force dut.frame_num = 16'hFFFE;
      @(negedge clk);
      release dut.frame_num;
      mdl_fn = 16'hFFFE;
      c  = '{2'd0, 6'h2A, 16'd3, 16'd1};
      nz = '{2'd3, 6'h2B, 16'd2, 16'd1};
      launch(c);
      run_frame(c, 1'b1, 1'b1, nz, di);
      check("wrap frame A number", 64'(obs_q[0].data[23:8]), 64'hFFFF);
      run_frame(nz, 1'b0, 1'b0, nz, di);
      check("wrap frame B number", 64'(obs_q[0].data[23:8]), 64'h0001);

      for (int r = 0; r < 6; r++) begin
         c.vc = 2'($urandom); c.dt = 6'($urandom_range(16, 63));
         c.wc = 16'($urandom_range(0, 48)); c.lines = 16'($urandom_range(0, 3));
         launch(c);
         run_frame(c, 1'b1, 1'b0, nz, di);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
